ram2_arbiter: RTL and testbench

Sequencing controller between the CPU pipeline and the external RAM2 SRAM chip. It accepts instruction-fetch requests from IF and data load/store requests from MEM, arbitrates them with data priority, and runs a multi-cycle SRAM read/write protocol on the chip pins. It raises `stallreq` while a request is outstanding and returns fetched words on registered outputs.

---
 rtl/ram2_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram2_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_arbiter.sv
// RAM2 SRAM sequencer: arbitrates IF fetches and MEM loads/stores (data first) onto one SRAM port.
// Optional one-entry fetch buffer compiled in with `define RAM2_INST_BUF_EN.
module ram2_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_re,
   input  logic [31:0]       pc,
   output logic [31:0]       inst,
   output logic              inst_ready,
   input  logic              mem_ce,
   input  logic              mem_re,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_data_i,
   output logic [31:0]       mem_data_o,
   output logic              mem_done,
   output logic              stallreq,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_data_o,
   input  logic [31:0]       ram_data_i,
   output logic              ram_data_oe,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACC,
      RD_LATCH,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [2:0]        wait_cnt;
   logic              src_fetch;
   logic              data_req;
   logic              idle_free;
   logic              take_data;
   logic              take_fetch;
   logic              take_buf;
   logic              buf_hit;
   logic [31:0]       buf_word;
   logic [ADDR_W-1:0] pc_word;
   logic [ADDR_W-1:0] data_word;
   logic              ce_n_d;
   logic              oe_n_d;
   logic              we_n_d;
   logic              data_oe_d;
   logic              inst_ready_d;
   logic              mem_done_d;
   logic              unused_addr_bits;

   assign data_req  = mem_ce && (mem_re || mem_we);
   assign pc_word   = pc[ADDR_W+1:2];
   assign data_word = mem_addr_i[ADDR_W+1:2];
   assign unused_addr_bits = ^{pc, mem_addr_i};

   // A done pulse blocks acceptance for one cycle so a requester can drop its request first.
   assign idle_free  = (state == IDLE) && !mem_done && !inst_ready;
   assign take_data  = idle_free && data_req;
   assign take_fetch = idle_free && !data_req && if_re && !buf_hit;
   assign take_buf   = idle_free && !data_req && if_re && buf_hit;

   assign stallreq = (data_req && !mem_done) || (if_re && !inst_ready);

`ifdef RAM2_INST_BUF_EN
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_tag;
   logic [31:0]       buf_data;

   assign buf_hit  = buf_valid && (buf_tag == pc_word);
   assign buf_word = buf_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
      end else if (state == RD_LATCH && src_fetch) begin
         buf_valid <= 1'b1;
         buf_tag   <= ram_addr;
         buf_data  <= ram_data_i;
      end else if (take_data && mem_we && data_word == buf_tag) begin
         buf_valid <= 1'b0;
      end
   end
`else
   assign buf_hit  = 1'b0;
   assign buf_word = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (take_data)       state_next = mem_we ? WR_SETUP : RD_ACC;
            else if (take_fetch) state_next = RD_ACC;
         end
         RD_ACC:   if (wait_cnt == 3'd0) state_next = RD_LATCH;
         RD_LATCH: state_next = IDLE;
         WR_SETUP: state_next = WR_PULSE;
         WR_PULSE: if (wait_cnt == 3'd0) state_next = WR_HOLD;
         WR_HOLD:  state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered pins line up with the state.
   always_comb begin
      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      data_oe_d = 1'b0;
      case (state_next)
         RD_ACC, RD_LATCH: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         WR_SETUP, WR_HOLD: begin
            ce_n_d    = 1'b0;
            data_oe_d = 1'b1;
         end
         WR_PULSE: begin
            ce_n_d    = 1'b0;
            we_n_d    = 1'b0;
            data_oe_d = 1'b1;
         end
         default: ;
      endcase
      inst_ready_d = (state == RD_LATCH && src_fetch) || take_buf;
      mem_done_d   = (state == RD_LATCH && !src_fetch) || (state == WR_HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt    <= 3'd0;
         src_fetch   <= 1'b0;
         inst        <= '0;
         mem_data_o  <= '0;
         inst_ready  <= 1'b0;
         mem_done    <= 1'b0;
         ram_addr    <= '0;
         ram_data_o  <= '0;
         ram_data_oe <= 1'b0;
         ram_ce_n    <= 1'b1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
      end else begin
         if (state_next != state)  wait_cnt <= 3'(WAIT_STATES);
         else if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;

         inst_ready  <= inst_ready_d;
         mem_done    <= mem_done_d;
         ram_ce_n    <= ce_n_d;
         ram_oe_n    <= oe_n_d;
         ram_we_n    <= we_n_d;
         ram_data_oe <= data_oe_d;

         if (take_data) begin
            src_fetch <= 1'b0;
            ram_addr  <= data_word;
            if (mem_we) ram_data_o <= mem_data_i;
         end else if (take_fetch) begin
            src_fetch <= 1'b1;
            ram_addr  <= pc_word;
         end

         if (state == RD_LATCH) begin
            if (src_fetch) inst       <= ram_data_i;
            else           mem_data_o <= ram_data_i;
         end else if (take_buf) begin
            inst <= buf_word;
         end
      end
   end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Scoreboard bench for ram2_arbiter with a behavioural SRAM; buffer-hit expectations follow RAM2_INST_BUF_EN.
module tb_ram2_arbiter;

   localparam int ADDR_W = 20;
`ifdef RAM2_INST_BUF_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_CE  = 0;
`else
   localparam int HIT_LAT = 3;
   localparam int HIT_CE  = 2;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              if_re;
   logic [31:0]       pc;
   logic [31:0]       inst;
   logic              inst_ready;
   logic              mem_ce;
   logic              mem_re;
   logic              mem_we;
   logic [31:0]       mem_addr_i;
   logic [31:0]       mem_data_i;
   logic [31:0]       mem_data_o;
   logic              mem_done;
   logic              stallreq;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_data_o;
   logic [31:0]       ram_data_i;
   logic              ram_data_oe;
   logic              ram_ce_n;
   logic              ram_oe_n;
   logic              ram_we_n;

   typedef struct {
      bit          is_inst;
      bit          has_data;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          we_low_cnt = 0;
   int          ce_low_cnt = 0;
   int          bus_conflicts = 0;
   int          done_seen = 0;
   logic [31:0] we_addr = '0;
   logic [31:0] sram [0:255];

   ram2_arbiter #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut (
      .clk(clk), .rst(rst),
      .if_re(if_re), .pc(pc), .inst(inst), .inst_ready(inst_ready),
      .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .mem_data_o(mem_data_o), .mem_done(mem_done), .stallreq(stallreq),
      .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
      .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: preloaded while reset is low, written on any clock with the write strobe low.
   assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (!rst) begin
         sram[4]  <= 32'h3C01_1234;
         sram[5]  <= 32'h5555_6666;
         sram[16] <= 32'h1111_2222;
      end else if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
         sram[ram_addr[7:0]] <= ram_data_o;
      end
   end

   always @(negedge clk) begin
      if (!ram_we_n) begin
         we_low_cnt <= we_low_cnt + 1;
         we_addr    <= 32'(ram_addr);
      end
      if (!ram_ce_n) ce_low_cnt <= ce_low_cnt + 1;
      if (ram_data_oe && !ram_oe_n) bus_conflicts <= bus_conflicts + 1;
      if (mem_done) done_seen <= done_seen + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic checkPulse(input bit is_inst, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_pulse", 32'(is_inst) + 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         checkOutput("pulse_kind", 32'(is_inst), 32'(e.is_inst));
         checkOutput("pulse_cycle", 32'(cyc), 32'(e.due));
         if (e.has_data) checkOutput(is_inst ? "inst_data" : "load_data", data, e.data);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest pending expectation.
   always @(negedge clk) begin
      if (inst_ready) checkPulse(1'b1, inst);
      if (mem_done)   checkPulse(1'b0, mem_data_o);
   end

   // kind: 0 fetch, 1 load, 2 store. Issues at a falling edge (cycle c0) and queues the expectation.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input int lat);
      exp_t e;
      @(negedge clk);
      e.is_inst  = (kind == 0);
      e.has_data = (kind != 2);
      e.data     = exp_data;
      e.due      = cyc + lat;
      exp_q.push_back(e);
      if (kind == 0) begin
         if_re = 1'b1;
         pc    = addr;
      end else begin
         mem_ce     = 1'b1;
         mem_re     = (kind == 1);
         mem_we     = (kind == 2);
         mem_addr_i = addr;
         mem_data_i = wdata;
      end
   endtask

   task automatic waitPulse(input bit want_inst);
      for (int i = 0; i < 40; i++) begin
         if (want_inst ? inst_ready : mem_done) return;
         @(negedge clk);
      end
      checkOutput(want_inst ? "timeout_inst_ready" : "timeout_mem_done", 32'd1, 32'd0);
   endtask

   task automatic finishAccess(input bit want_inst);
      waitPulse(want_inst);
      if (want_inst) if_re = 1'b0;
      else begin
         mem_ce = 1'b0;
         mem_re = 1'b0;
         mem_we = 1'b0;
      end
   endtask

   initial begin
      int we_base;
      int ce_base;
      int done_base;

      rst = 1'b0; if_re = 1'b0; pc = '0;
      mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0; mem_addr_i = '0; mem_data_i = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_mem_data_o", mem_data_o, 32'h0);
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
      checkOutput("rst_ram_data_o", ram_data_o, 32'h0);
      checkOutput("rst_pulses_oe", {29'd0, inst_ready, mem_done, ram_data_oe}, 32'h0);
      checkOutput("rst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
      checkOutput("rst_stallreq", 32'(stallreq), 32'h0);
      rst = 1'b1;

      applyStimulus(0, 32'h0000_0010, 32'h0, 32'h3C01_1234, 3);
      #1 checkOutput("fetch_stall_c0", 32'(stallreq), 32'h1);
      @(negedge clk);
      checkOutput("fetch_addr_c1", 32'(ram_addr), 32'h4);
      checkOutput("fetch_strobes_c1", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h1);
      checkOutput("fetch_stall_c1", 32'(stallreq), 32'h1);
      @(negedge clk);
      checkOutput("fetch_stall_c2", 32'(stallreq), 32'h1);
      finishAccess(1'b1);
      checkOutput("fetch_stall_done", 32'(stallreq), 32'h0);

      we_base = we_low_cnt;
      applyStimulus(2, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 4);
      finishAccess(1'b0);
      checkOutput("store_we_cycles", 32'(we_low_cnt - we_base), 32'd1);
      checkOutput("store_we_addr", we_addr, 32'h8);
      checkOutput("store_bus_conflict", 32'(bus_conflicts), 32'd0);
      checkOutput("store_ram_data_o", ram_data_o, 32'hDEAD_BEEF);
      applyStimulus(1, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 3);
      finishAccess(1'b0);

      // Fetch and load together: load at c3, fetch at c7.
      applyStimulus(1, 32'h0000_0040, 32'h0, 32'h1111_2222, 3);
      exp_q.push_back('{is_inst: 1'b1, has_data: 1'b1, data: 32'h5555_6666, due: cyc + 7});
      if_re = 1'b1;
      pc    = 32'h0000_0014;
      finishAccess(1'b0);
      checkOutput("combo_ce_idle_c3", 32'(ram_ce_n), 32'h1);
      checkOutput("combo_stall_c3", 32'(stallreq), 32'h1);
      @(negedge clk);
      checkOutput("combo_ce_idle_c4", 32'(ram_ce_n), 32'h1);
      finishAccess(1'b1);
      checkOutput("combo_mem_data_o", mem_data_o, 32'h1111_2222);

      // Reset dropped during the write pulse: abandon without a done pulse.
      done_base = done_seen;
      @(negedge clk);
      mem_ce = 1'b1; mem_we = 1'b1; mem_re = 1'b0;
      mem_addr_i = 32'h0000_0030; mem_data_i = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort_pulse_seen", 32'(ram_we_n), 32'h0);
      rst = 1'b0;
      mem_ce = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      checkOutput("abort_we_n", 32'(ram_we_n), 32'h1);
      checkOutput("abort_data_oe", 32'(ram_data_oe), 32'h0);
      checkOutput("abort_ce_n", 32'(ram_ce_n), 32'h1);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_seen - done_base), 32'd0);

      // Repeat fetch: a buffer hit when compiled in, otherwise a full SRAM read.
      applyStimulus(0, 32'h0000_0010, 32'h0, 32'h3C01_1234, 3);
      finishAccess(1'b1);
      ce_base = ce_low_cnt;
      applyStimulus(0, 32'h0000_0010, 32'h0, 32'h3C01_1234, HIT_LAT);
      finishAccess(1'b1);
      checkOutput("refetch_ce_cycles", 32'(ce_low_cnt - ce_base), 32'(HIT_CE));
      applyStimulus(2, 32'h0000_0010, 32'h1234_5678, 32'h0, 4);
      finishAccess(1'b0);
      ce_base = ce_low_cnt;
      applyStimulus(0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3);
      finishAccess(1'b1);
      checkOutput("after_store_ce_cycles", 32'(ce_low_cnt - ce_base), 32'd2);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("final_bus_conflicts", 32'(bus_conflicts), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
